// File: rtl/pre_if_fetch_if.sv
// ============================================================================
// pre_if_fetch_if : SRAM-like instruction-bus bundle (req/addr_ok/data_ok)
// Rev 1.0
// ============================================================================
`default_nettype none

interface pre_if_fetch_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/pre_if_fetch.sv
// ============================================================================
// pre_if_fetch : pre-IF stage, owns fetch PC, drops stale responses after a
//                redirect, holds one {inst,pc} for IF. Option: PF_ADEF_CHK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pre_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          CANCEL_W = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pre_if_fetch_if.master         inst_sram,
    input  wire logic              if_allowin,
    output logic                   pf_to_if_valid,
`ifdef PF_ADEF_CHK_EN
    output logic [64:0]            pf_to_if_bus,
`else
    output logic [63:0]            pf_to_if_bus,
`endif
    input  wire logic [32:0]       br_bus,
    input  wire logic              flush,
    input  wire logic [31:0]       flush_target
);

    typedef enum logic [0:0] {S_REQ = 1'b0, S_WAIT = 1'b1} state_e;

    localparam logic [CANCEL_W-1:0] CNT_MAX  = '1;
    localparam logic [CANCEL_W-1:0] CNT_ZERO = '0;
    localparam logic [CANCEL_W-1:0] CNT_ONE  = {{(CANCEL_W-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [31:0]           fetch_pc_q, fetch_pc_d;
    logic [31:0]           req_pc_q, req_pc_d;
    logic [CANCEL_W-1:0]   cancel_q, cancel_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [31:0]           buf_inst_q, buf_inst_d;
    logic [31:0]           buf_pc_q, buf_pc_d;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_req;
    logic        w_fire;
    logic        w_data_live;
    logic        w_data_stale;
    logic        w_adef_blk;
    logic        w_inc;

    assign w_redirect    = flush | br_bus[32];
    assign w_redirect_pc = flush ? flush_target : br_bus[31:0];

`ifdef PF_ADEF_CHK_EN
    // Misaligned redirect targets park the stage until the next redirect.
    logic adef_q, adef_d;
    logic buf_adef_q, buf_adef_d;
    assign w_adef_blk   = adef_q;
    assign pf_to_if_bus = {buf_adef_q, buf_inst_q, buf_pc_q};
`else
    assign w_adef_blk   = 1'b0;
    assign pf_to_if_bus = {buf_inst_q, buf_pc_q};
`endif

    assign w_req = !reset && (state_q == S_REQ) && (!buf_valid_q || if_allowin)
                   && (cancel_q != CNT_MAX) && !w_redirect && !w_adef_blk;
    assign w_fire       = w_req & inst_sram.inst_sram_addr_ok;
    assign w_data_live  = inst_sram.inst_sram_data_ok && (cancel_q == CNT_ZERO) && (state_q == S_WAIT);
    assign w_data_stale = inst_sram.inst_sram_data_ok && (cancel_q != CNT_ZERO);

    assign inst_sram.inst_sram_req  = w_req;
    assign inst_sram.inst_sram_wr   = 1'b0;
    assign inst_sram.inst_sram_size = 2'b10;
    assign inst_sram.inst_sram_addr = fetch_pc_q;
    assign pf_to_if_valid           = buf_valid_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        buf_pc_d    = buf_pc_q;
        cancel_d    = cancel_q;
        w_inc       = 1'b0;
`ifdef PF_ADEF_CHK_EN
        adef_d      = adef_q;
        buf_adef_d  = buf_adef_q;
`endif
        if (buf_valid_q && if_allowin) begin
            buf_valid_d = 1'b0;
        end
        if (w_redirect) begin
            fetch_pc_d  = w_redirect_pc;
            buf_valid_d = 1'b0;
            state_d     = S_REQ;
            // A live response landing this cycle is consumed by the drop itself.
            if (state_q == S_WAIT && !w_data_live) begin
                w_inc = 1'b1;
            end
`ifdef PF_ADEF_CHK_EN
            adef_d = |w_redirect_pc[1:0];
            if (|w_redirect_pc[1:0]) begin
                buf_valid_d = 1'b1;
                buf_adef_d  = 1'b1;
                buf_inst_d  = 32'h0;
                buf_pc_d    = w_redirect_pc;
            end
`endif
        end else begin
            if (w_fire) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                state_d    = S_WAIT;
            end
            if (w_data_live) begin
                buf_inst_d  = inst_sram.inst_sram_rdata;
                buf_pc_d    = req_pc_q;
                buf_valid_d = 1'b1;
                state_d     = S_REQ;
`ifdef PF_ADEF_CHK_EN
                buf_adef_d  = 1'b0;
`endif
            end
        end
        if (w_inc && !w_data_stale && cancel_q != CNT_MAX) begin
            cancel_d = cancel_q + CNT_ONE;
        end else if (w_data_stale && !w_inc) begin
            cancel_d = cancel_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= 32'h0;
            cancel_q    <= CNT_ZERO;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 32'h0;
            buf_pc_q    <= 32'h0;
`ifdef PF_ADEF_CHK_EN
            adef_q      <= 1'b0;
            buf_adef_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            cancel_q    <= cancel_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc_q    <= buf_pc_d;
`ifdef PF_ADEF_CHK_EN
            adef_q      <= adef_d;
            buf_adef_q  <= buf_adef_d;
`endif
        end
    end

endmodule

`default_nettype wire
